// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: operand-stack controller for the RPN calculator.
// Accepts single-cycle push/pop/operator pulses, keeps a register-file stack
// and runs operators through an IDLE -> FETCH -> EXEC -> WB sequence with a
// signed W-bit ALU. Presents the signed top-of-stack plus LED status flags.
//
// Optional build macro: RPN_SAT_EN -- when defined, overflowing operator
// results are clamped to the signed W-bit range instead of wrapping.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   data_in[W]           signed value to push
//   push_pulse           push command (highest priority)
//   pop_pulse            pop command
//   op_pulse, op_sel[2]  operator command: 00 add, 01 sub, 10 mul, 11 negate
//   top[W]               signed top-of-stack, 0 when empty
//   top_valid            stack non-empty
//   depth[clog2(DEPTH)+1] current entry count
//   busy                 operator in progress
//   empty, full          stack occupancy flags
//   err                  last accepted command failed (under/overflow)
//   ovf                  last operator result out of signed W-bit range
module rpn_stack_ctrl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic signed [W-1:0]       data_in,
   input  logic                      push_pulse,
   input  logic                      pop_pulse,
   input  logic                      op_pulse,
   input  logic [1:0]                op_sel,
   output logic signed [W-1:0]       top,
   output logic                      top_valid,
   output logic [$clog2(DEPTH):0]    depth,
   output logic                      busy,
   output logic                      empty,
   output logic                      full,
   output logic                      err,
   output logic                      ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;
   localparam int unsigned PW = 2 * W;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_NEG = 2'b11;

   localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DW-1:0]         r_depth;
   logic signed [W-1:0]   r_mem [DEPTH];
   logic [1:0]            r_op;
   logic signed [W-1:0]   r_a;
   logic signed [W-1:0]   r_b;
   logic signed [W-1:0]   r_res;
   logic                  r_err;
   logic                  r_ovf;

   logic                  w_empty;
   logic                  w_full;
   logic [AW-1:0]         w_top_idx;
   logic [AW-1:0]         w_sec_idx;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic                  w_op_ok;
   logic                  w_cmd_fail;
   logic                  w_depth_ok;

   logic signed [PW-1:0]  w_a_ext;
   logic signed [PW-1:0]  w_b_ext;
   logic signed [PW-1:0]  w_wide;
   logic signed [W-1:0]   w_wrap;
   logic                  w_ovf;
   logic signed [W-1:0]   w_res;

   logic                  w_wr_en;
   logic [AW-1:0]         w_wr_idx;
   logic signed [W-1:0]   w_wr_data;

   assign w_empty   = (r_depth == '0);
   assign w_full    = (r_depth == DW'(DEPTH));
   assign w_top_idx = AW'(r_depth - DW'(1));
   assign w_sec_idx = AW'(r_depth - DW'(2));

   // Command decode in IDLE (push > pop > op) and operator sequencing.
   always_comb begin
      w_state_nxt = r_state;
      w_push_ok   = 1'b0;
      w_pop_ok    = 1'b0;
      w_op_ok     = 1'b0;
      w_cmd_fail  = 1'b0;
      w_depth_ok  = (op_sel == OP_NEG) ? (r_depth >= DW'(1)) : (r_depth >= DW'(2));
      case (r_state)
         S_IDLE: begin
            if (push_pulse) begin
               if (w_full) w_cmd_fail = 1'b1;
               else        w_push_ok  = 1'b1;
            end else if (pop_pulse) begin
               if (w_empty) w_cmd_fail = 1'b1;
               else         w_pop_ok   = 1'b1;
            end else if (op_pulse) begin
               if (w_depth_ok) begin
                  w_op_ok     = 1'b1;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_cmd_fail  = 1'b1;
               end
            end
         end
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = S_WB;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ALU: every operation is exact in 2W bits, so range check is a sign-extension compare.
   always_comb begin
      w_a_ext = {{W{r_a[W-1]}}, r_a};
      w_b_ext = {{W{r_b[W-1]}}, r_b};
      case (r_op)
         OP_ADD:  w_wide = w_a_ext + w_b_ext;
         OP_SUB:  w_wide = w_a_ext - w_b_ext;
         OP_MUL:  w_wide = w_a_ext * w_b_ext;
         default: w_wide = -w_b_ext;
      endcase
      w_wrap = w_wide[W-1:0];
      w_ovf  = (w_wide != {{W{w_wrap[W-1]}}, w_wrap});
`ifdef RPN_SAT_EN
      if (w_ovf) w_res = w_wide[PW-1] ? SMIN : SMAX;
      else       w_res = w_wrap;
`else
      w_res = w_wrap;
`endif
   end

   // Single stack write port: push in IDLE or operator writeback in WB.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = '0;
      w_wr_data = '0;
      if (w_push_ok) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = AW'(r_depth);
         w_wr_data = data_in;
      end else if (r_state == S_WB) begin
         w_wr_en   = 1'b1;
         w_wr_idx  = (r_op == OP_NEG) ? w_top_idx : w_sec_idx;
         w_wr_data = r_res;
      end
   end

   // Stack storage; reset only blocks the write so no partial writeback occurs.
   always_ff @(posedge clock) begin
      if (!reset && w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
   end

   // State, depth, operand/result registers and status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_depth <= '0;
         r_op    <= OP_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_err   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push_ok) begin
            r_depth <= r_depth + DW'(1);
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (w_pop_ok) begin
            r_depth <= r_depth - DW'(1);
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (w_op_ok) begin
            r_op    <= op_sel;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
         end else if (w_cmd_fail) begin
            r_err   <= 1'b1;
         end
         case (r_state)
            S_FETCH: begin
               r_b <= r_mem[w_top_idx];
               r_a <= r_mem[w_sec_idx];
            end
            S_EXEC: begin
               r_res <= w_res;
               r_ovf <= w_ovf;
            end
            S_WB: begin
               if (r_op != OP_NEG) r_depth <= r_depth - DW'(1);
            end
            default: ;
         endcase
      end
   end

   assign top       = w_empty ? '0 : r_mem[w_top_idx];
   assign top_valid = ~w_empty;
   assign depth     = r_depth;
   assign busy      = (r_state != S_IDLE);
   assign empty     = w_empty;
   assign full      = w_full;
   assign err       = r_err;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb_rpn_stack_ctrl: bench for rpn_stack_ctrl with a queue-based stack model,
// directed scenarios with literal expectations, and randomized pulses.
module tb_rpn_stack_ctrl;

   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 8;

   logic                clock = 1'b0;
   logic                reset;
   logic signed [W-1:0] data_in;
   logic                push_pulse;
   logic                pop_pulse;
   logic                op_pulse;
   logic [1:0]          op_sel;
   logic signed [W-1:0] top;
   logic                top_valid;
   logic [3:0]          depth;
   logic                busy;
   logic                empty;
   logic                full;
   logic                err;
   logic                ovf;

   int n_vec = 0;
   int n_mis = 0;

   rpn_stack_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .data_in    (data_in),
      .push_pulse (push_pulse),
      .pop_pulse  (pop_pulse),
      .op_pulse   (op_pulse),
      .op_sel     (op_sel),
      .top        (top),
      .top_valid  (top_valid),
      .depth      (depth),
      .busy       (busy),
      .empty      (empty),
      .full       (full),
      .err        (err),
      .ovf        (ovf)
   );

   always #5 clock = ~clock;

   // Behavioural model: stack as a queue, operator as a 3-cycle countdown.
   logic signed [W-1:0] m_stk [$];
   int                  m_phase = 0;
   logic [1:0]          m_op    = 2'b00;
   logic                m_err   = 1'b0;
   logic                m_ovf   = 1'b0;
   logic signed [W-1:0] m_res   = '0;
   bit                  m_live  = 1'b0;

   function automatic void calc(input int a, input int b, input logic [1:0] op,
                                output logic signed [W-1:0] res, output logic ov);
      int t;
      case (op)
         2'b00:   t = a + b;
         2'b01:   t = a - b;
         2'b10:   t = a * b;
         default: t = -b;
      endcase
      ov = (t > 127) || (t < -128);
`ifdef RPN_SAT_EN
      if (ov) res = (t > 0) ? 8'h7F : 8'h80;
      else    res = 8'(t);
`else
      res = 8'(t);
`endif
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_stk.delete();
         m_phase = 0;
         m_err   = 1'b0;
         m_ovf   = 1'b0;
         m_live  = 1'b1;
      end else if (m_phase > 0) begin
         m_phase = m_phase - 1;
         if (m_phase == 1) begin
            int a, b;
            b = int'(m_stk[$]);
            a = (m_op == 2'b11) ? 0 : int'(m_stk[m_stk.size()-2]);
            calc(a, b, m_op, m_res, m_ovf);
         end else if (m_phase == 0) begin
            if (m_op != 2'b11) void'(m_stk.pop_back());
            m_stk[m_stk.size()-1] = m_res;
         end
      end else if (push_pulse) begin
         if (m_stk.size() == DEPTH) m_err = 1'b1;
         else begin
            m_stk.push_back(data_in);
            m_err = 1'b0;
            m_ovf = 1'b0;
         end
      end else if (pop_pulse) begin
         if (m_stk.size() == 0) m_err = 1'b1;
         else begin
            void'(m_stk.pop_back());
            m_err = 1'b0;
            m_ovf = 1'b0;
         end
      end else if (op_pulse) begin
         if (m_stk.size() < ((op_sel == 2'b11) ? 1 : 2)) m_err = 1'b1;
         else begin
            m_op    = op_sel;
            m_err   = 1'b0;
            m_ovf   = 1'b0;
            m_phase = 3;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clock) begin
      if (m_live) begin
         int  e_top, e_dep;
         bit  e_busy;
         e_dep  = m_stk.size();
         e_top  = (e_dep == 0) ? 0 : int'(m_stk[$]);
         e_busy = (m_phase != 0);
         n_vec++;
         if (int'(top) != e_top || int'(depth) != e_dep || top_valid != (e_dep != 0) ||
             empty != (e_dep == 0) || full != (e_dep == DEPTH) || busy != e_busy ||
             err != m_err || ovf != m_ovf) begin
            n_mis++;
            $display("FAIL model t=%0t: act top=%0d depth=%0d tv=%0b busy=%0b empty=%0b full=%0b err=%0b ovf=%0b | exp top=%0d depth=%0d busy=%0b err=%0b ovf=%0b",
                     $time, top, depth, top_valid, busy, empty, full, err, ovf,
                     e_top, e_dep, e_busy, m_err, m_ovf);
         end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic rs, input logic pu, input logic po, input logic op,
                       input logic [1:0] sel, input logic [7:0] d);
      reset      = rs;
      push_pulse = pu;
      pop_pulse  = po;
      op_pulse   = op;
      op_sel     = sel;
      data_in    = d;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
   endtask

   task automatic do_rst();
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
   endtask

   task automatic do_push(input int v);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'(v));
   endtask

   task automatic do_pop();
      step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
   endtask

   task automatic do_op(input logic [1:0] sel);
      step(1'b0, 1'b0, 1'b0, 1'b1, sel, 8'h00);
   endtask

   initial begin
      do_rst();
      lit("rst_depth", int'(depth), 0);
      lit("rst_empty", int'(empty), 1);
      lit("rst_top", int'(top), 0);

      // add: busy for exactly three cycles, result visible on the fourth
      do_push(5);
      do_push(3);
      do_op(2'b00);
      lit("add_busy1", int'(busy), 1);
      idle(2);
      lit("add_busy3", int'(busy), 1);
      idle(1);
      lit("add_busy_done", int'(busy), 0);
      lit("add_top", int'(top), 8);
      lit("add_depth", int'(depth), 1);
      lit("add_err", int'(err), 0);

      // sub then negate
      do_rst();
      do_push(7);
      do_push(10);
      do_op(2'b01);
      idle(3);
      lit("sub_top", int'(top), -3);
      lit("sub_depth", int'(depth), 1);
      do_op(2'b11);
      idle(3);
      lit("neg_top", int'(top), 3);
      lit("neg_depth", int'(depth), 1);

      // overflow on add, cleared by the next push
      do_rst();
      do_push(-100);
      do_push(-100);
      do_op(2'b00);
      idle(3);
      lit("ovf_flag", int'(ovf), 1);
`ifdef RPN_SAT_EN
      lit("ovf_top", int'(top), -128);
`else
      lit("ovf_top", int'(top), 56);
`endif
      do_push(1);
      lit("ovf_clear", int'(ovf), 0);

      // underflow errors
      do_rst();
      do_pop();
      lit("pop_empty_err", int'(err), 1);
      lit("pop_empty_depth", int'(depth), 0);
      do_push(9);
      do_op(2'b00);
      lit("op_short_err", int'(err), 1);
      lit("op_short_busy", int'(busy), 0);
      lit("op_short_top", int'(top), 9);

      // fill to DEPTH, then overflow push
      do_rst();
      for (int i = 1; i <= DEPTH + 1; i++) begin
         do_push(i);
         if (i == DEPTH - 1) lit("full_early", int'(full), 0);
         if (i == DEPTH)     lit("full_set", int'(full), 1);
      end
      lit("push_full_err", int'(err), 1);
      lit("push_full_top", int'(top), DEPTH);

      // push while in EXEC is dropped
      do_rst();
      do_push(4);
      do_push(6);
      do_op(2'b10);
      idle(1);
      do_push(99);
      idle(1);
      lit("mul_top", int'(top), 24);
      lit("mul_depth", int'(depth), 1);

      // reset while in EXEC
      do_rst();
      do_push(4);
      do_push(6);
      do_op(2'b10);
      idle(1);
      do_rst();
      lit("rst_exec_depth", int'(depth), 0);
      lit("rst_exec_busy", int'(busy), 0);
      lit("rst_exec_top", int'(top), 0);
      idle(3);
      lit("rst_exec_after", int'(depth), 0);

      // randomized pulses, checked cycle by cycle against the model
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
              2'($urandom_range(0, 3)), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
